instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//   Front end of the single-cycle core: owns the PC, fetches 32-bit words from instruction memory
//   over a req/valid handshake, decodes them into the control/field bus that drives the datapath
//   (opcode, Funct3, Funct7, RS1, RS2, RD, Imm_reg, Shamt, write_en, read_en), and holds each
//   decoded instruction until the datapath accepts it. Accepts branch/jump redirects from the ALU.
// PARAMETERS
//   WIDTH     32            PC / address / instruction width
//   RESET_PC  32'h0000_0000 PC loaded on reset (bits [1:0] forced to 0)
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst          in   1      asynchronous, active-low reset
//   imem_req     out  1      fetch request, held until imem_valid
//   imem_addr    out  WIDTH  fetch address (= pc), stable while imem_req=1
//   imem_valid   in   1      instruction word present on imem_rdata this cycle
//   imem_rdata   in   WIDTH  fetched instruction word
//   stall        in   1      datapath busy; current instruction not accepted this cycle
//   redirect_en  in   1      take redirect_pc as next PC
//   redirect_pc  in   WIDTH  branch/jump target
//   pc           out  WIDTH  PC of instruction currently issued
//   instr_valid  out  1      decoded outputs valid
//   opcode       out  7      instr[6:0]
//   Funct3       out  3      instr[14:12]
//   Funct7       out  7      instr[31:25]
//   RS1/RS2/RD   out  5 each instr[19:15] / instr[24:20] / instr[11:7]
//   Imm_reg      out  12     12-bit immediate, format per opcode (below)
//   Shamt        out  5      instr[24:20]
//   write_en     out  1      register-file write strobe for this instruction
//   read_en      out  1      data-memory read (load)
//   illegal      out  1      unsupported encoding
// BEHAVIOUR
// - States: IDLE -> FETCH -> ISSUE -> FETCH ... All outputs registered.
// - Reset (rst=0, async): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, all decoded outputs,
//   write_en, read_en, illegal = 0, squash=0. Reset mid-fetch abandons the request; the next
//   imem_valid is ignored until FETCH is re-entered.
// - IDLE: one cycle after rst release, then FETCH.
// - FETCH: imem_req=1, imem_addr=pc. On imem_valid: capture + decode, go ISSUE next cycle with
//   instr_valid=1. Min latency imem_req rise -> instr_valid = 1 cycle after imem_valid.
// - ISSUE: instr_valid=1, imem_req=0; all decoded outputs stable while stall=1.
//   Accept = instr_valid & ~stall. On accept: pc <= redirect_en ? {redirect_pc[W-1:2],2'b00}
//   : pc+4 (mod 2^WIDTH, wraps to 0); instr_valid drops; state FETCH.
// - Redirect during FETCH: set squash, pc <= aligned redirect_pc; imem_req held; the outstanding
//   imem_valid response is discarded (squash cleared), refetch at new pc. Redirect during ISSUE
//   with stall=1 is ignored; caller must hold it until accept. Redirect+imem_valid in same cycle:
//   redirect wins, word discarded.
// - Decode (opcode -> write_en/read_en/Imm_reg):
//   0110011 R: 1/0, Imm_reg=instr[31:20]    0010011 I-ALU: 1/0, instr[31:20]
//   0000011 LOAD: 1/1, instr[31:20]          0100011 STORE: 0/0, {instr[31:25],instr[11:7]}
//   1100011 BRANCH: 0/0, {instr[31],instr[7],instr[30:25],instr[11:8]}
//   0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR: 1/0, instr[31:20]
//   anything else, or instr[1:0]!=2'b11: illegal=1, write_en=read_en=0, instr_valid still 1.
// - RD=0 does not suppress write_en (register file ignores x0 writes).
// TESTING
// 1 Reset release, imem_valid same cycle as req, rdata=32'h00500093 (addi x1,x0,5) -> imem_addr=0,
//   then instr_valid=1, opcode=0010011, RD=1, Imm_reg=12'h005, write_en=1, read_en=0, next addr 4.
// 2 Load 32'h0040A103 with stall=1 for 3 cycles -> outputs stable 3 cycles, read_en=1, RD=2,
//   Imm_reg=4; on stall=0 next imem_addr=8.
// 3 Accept with redirect_en=1, redirect_pc=32'h0000_0103 -> next imem_addr=32'h0000_0100.
// 4 Redirect to 32'h40 while FETCH waits 2 cycles -> first imem_valid word dropped, refetch
//   at 32'h40, only that word issued.
// 5 rdata=32'hFFFFFFFF -> illegal=1, write_en=0, read_en=0; pc=32'hFFFF_FFFC accept -> next pc 0.
// 6 Assert rst mid-ISSUE -> instr_valid=0, imem_req=0 immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: owns the PC, fetches over a req/valid handshake, decodes each word
// into the datapath control/field bus and holds it until the datapath accepts it.
module instr_fetch_decode #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc,
  output logic             instr_valid,
  output logic [6:0]       opcode,
  output logic [2:0]       Funct3,
  output logic [6:0]       Funct7,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic [4:0]       RD,
  output logic [11:0]      Imm_reg,
  output logic [4:0]       Shamt,
  output logic             write_en,
  output logic             read_en,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

  state_t           state;
  logic             squash;
  logic [WIDTH-1:0] target_pc;
  logic             dec_we;
  logic             dec_re;
  logic             dec_ill;
  logic [11:0]      dec_imm;

  assign target_pc = redirect_pc & ALIGN_MASK;
  assign imem_addr = pc;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    dec_we  = 1'b0;
    dec_re  = 1'b0;
    dec_ill = 1'b0;
    dec_imm = imem_rdata[31:20];
    if (imem_rdata[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (imem_rdata[6:0])
        OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: dec_we = 1'b1;
        OP_LOAD: begin
          dec_we = 1'b1;
          dec_re = 1'b1;
        end
        OP_STORE:  dec_imm = {imem_rdata[31:25], imem_rdata[11:7]};
        OP_BRANCH: dec_imm = {imem_rdata[31], imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8]};
        default:   dec_ill = 1'b1;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      opcode      <= '0;
      Funct3      <= '0;
      Funct7      <= '0;
      RS1         <= '0;
      RS2         <= '0;
      RD          <= '0;
      Imm_reg     <= '0;
      Shamt       <= '0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect_en) begin
            // A response arriving in the redirect cycle is dropped here, so only an
            // still-outstanding response needs to be squashed later.
            pc     <= target_pc;
            squash <= ~imem_valid;
          end else if (imem_valid) begin
            if (squash) begin
              squash <= 1'b0;
            end else begin
              opcode      <= imem_rdata[6:0];
              Funct3      <= imem_rdata[14:12];
              Funct7      <= imem_rdata[31:25];
              RS1         <= imem_rdata[19:15];
              RS2         <= imem_rdata[24:20];
              RD          <= imem_rdata[11:7];
              Shamt       <= imem_rdata[24:20];
              Imm_reg     <= dec_imm;
              write_en    <= dec_we;
              read_en     <= dec_re;
              illegal     <= dec_ill;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc          <= redirect_en ? target_pc : pc + WIDTH'(4);
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: stimulus pushes expected issued instructions into a
// queue, a monitor pops one per issued instruction and checks it every cycle it is held.
`timescale 1ns/1ps
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  RS1, RS2, RD;
  logic [11:0] Imm_reg;
  logic [4:0]  Shamt;
  logic        write_en, read_en, illegal;

  instr_fetch_decode #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .pc(pc), .instr_valid(instr_valid),
    .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
    .RS1(RS1), .RS2(RS2), .RD(RD),
    .Imm_reg(Imm_reg), .Shamt(Shamt),
    .write_en(write_en), .read_en(read_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic        we;
    logic        re;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur  = 1'b0;
  bit   presented = 1'b0;
  int   tests  = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [11:0] imm,
                              input logic we, input logic re, input logic ill);
    exp_t e;
    e.pc = p; e.op = op; e.f3 = f3; e.f7 = f7; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.we = we; e.re = re; e.ill = ill;
    return e;
  endfunction

  // Monitor: one pop per newly presented instruction, field checks on every held cycle.
  always @(posedge clk) begin
    #1;
    if (!instr_valid) begin
      presented = 1'b0;
    end else begin
      if (!presented) begin
        presented = 1'b1;
        if (exp_q.size() == 0) begin
          have_cur = 1'b0;
          check("unexpected issue pc", pc, 32'hxxxx_xxxx);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        check("pc",       pc,                cur.pc);
        check("opcode",   {25'd0, opcode},   {25'd0, cur.op});
        check("Funct3",   {29'd0, Funct3},   {29'd0, cur.f3});
        check("Funct7",   {25'd0, Funct7},   {25'd0, cur.f7});
        check("RS1",      {27'd0, RS1},      {27'd0, cur.rs1});
        check("RS2",      {27'd0, RS2},      {27'd0, cur.rs2});
        check("RD",       {27'd0, RD},       {27'd0, cur.rd});
        check("Shamt",    {27'd0, Shamt},    {27'd0, cur.rs2});
        if (!cur.ill) check("Imm_reg", {20'd0, Imm_reg}, {20'd0, cur.imm});
        check("write_en", {31'd0, write_en}, {31'd0, cur.we});
        check("read_en",  {31'd0, read_en},  {31'd0, cur.re});
        check("illegal",  {31'd0, illegal},  {31'd0, cur.ill});
        check("imem_req low in issue", {31'd0, imem_req}, 32'd0);
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("imem_req raised", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("instr_valid raised", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input exp_t e,
                       input int delay);
    wait_req();
    check("imem_addr", imem_addr, addr);
    repeat (delay) @(negedge clk);
    exp_q.push_back(e);
    imem_valid = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_valid = 1'b0;
  endtask

  task automatic issue(input int hold, input logic redir, input logic [31:0] rpc);
    wait_valid();
    stall = 1'b1;
    repeat (hold) @(negedge clk);
    stall       = 1'b0;
    redirect_en = redir;
    redirect_pc = rpc;
    @(negedge clk);
    redirect_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst imem_req",    {31'd0, imem_req},    32'd0);
    check("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst pc",          pc,                   32'd0);
    check("rst opcode",      {25'd0, opcode},      32'd0);
    check("rst Imm_reg",     {20'd0, Imm_reg},     32'd0);
    check("rst write_en",    {31'd0, write_en},    32'd0);
    check("rst read_en",     {31'd0, read_en},     32'd0);
    check("rst illegal",     {31'd0, illegal},     32'd0);
    @(negedge clk);
    rst = 1'b1;

    // addi x1,x0,5 answered in the first request cycle
    fetch(32'h0, 32'h0050_0093, mk(32'h0, 7'h13, 3'd0, 7'h00, 5'd0, 5'd5, 5'd1, 12'h005, 1, 0, 0), 0);
    issue(0, 1'b0, 32'h0);

    // lw x2,4(x1) held by a 3-cycle stall
    fetch(32'h4, 32'h0040_A103, mk(32'h4, 7'h03, 3'd2, 7'h00, 5'd1, 5'd4, 5'd2, 12'h004, 1, 1, 0), 1);
    issue(3, 1'b0, 32'h0);

    // add x3,x1,x2 accepted with a misaligned redirect target
    fetch(32'h8, 32'h0020_81B3, mk(32'h8, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 12'h002, 1, 0, 0), 0);
    issue(1, 1'b1, 32'h0000_0103);

    // sw x2,8(x1) at the aligned redirect target
    fetch(32'h100, 32'h0020_A423, mk(32'h100, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd8, 12'h008, 0, 0, 0), 0);
    issue(0, 1'b0, 32'h0);

    // Redirect while the fetch at 0x104 is outstanding; its late response must be dropped
    wait_req();
    check("imem_addr pre-redirect", imem_addr, 32'h104);
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_en = 1'b0;
    check("imem_addr after redirect", imem_addr, 32'h40);
    check("imem_req held", {31'd0, imem_req}, 32'd1);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_valid = 1'b0;
    check("squashed word not issued", {31'd0, instr_valid}, 32'd0);
    fetch(32'h40, 32'h8020_84E3, mk(32'h40, 7'h63, 3'd0, 7'h40, 5'd1, 5'd2, 5'd9, 12'hC04, 0, 0, 0), 0);
    issue(0, 1'b1, 32'hFFFF_FFFF);

    // Illegal word at the top of memory, then PC wraps to 0
    fetch(32'hFFFF_FFFC, 32'hFFFF_FFFF,
          mk(32'hFFFF_FFFC, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 12'h000, 0, 0, 1), 0);
    issue(0, 1'b0, 32'h0);

    // lui x1,0x12345 at the wrapped PC, interrupted by reset while stalled
    fetch(32'h0, 32'h1234_50B7, mk(32'h0, 7'h37, 3'd5, 7'h09, 5'd8, 5'd3, 5'd1, 12'h123, 1, 0, 0), 0);
    wait_valid();
    stall = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("async rst instr_valid", {31'd0, instr_valid}, 32'd0);
    check("async rst imem_req",    {31'd0, imem_req},    32'd0);
    check("async rst pc",          pc,                   32'd0);
    check("async rst write_en",    {31'd0, write_en},    32'd0);
    @(negedge clk);
    rst        = 1'b1;
    stall      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_valid = 1'b0;
    check("idle ignores imem_valid", {31'd0, instr_valid}, 32'd0);

    // jal x0,0: rd=0 still writes
    fetch(32'h0, 32'h0000_006F, mk(32'h0, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 12'h000, 1, 0, 0), 0);
    issue(1, 1'b0, 32'h0);
    check("next fetch addr after jal", imem_addr, 32'h4);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
